l2_request_queue: RTL and testbench



---
 rtl/l2_request_queue.sv | 125 ++++++++++++
 tb/tb_l2_request_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_queue.sv
// L1->L2 request FIFO with a single-entry issue register and per-type issue counters.
// Optional L2_DEDUP_EN: drop a READ/RFO identical to the newest entry still queued.
module l2_request_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 32
) (
  input  logic                     Clock,
  input  logic                     clear,
  input  logic [1:0]               cmd_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [1:0]               l2_cmd,
  output logic [ADDR_W-1:0]        l2_addr,
  output logic                     l2_valid,
  input  logic                     l2_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         reads_issued,
  output logic [CNT_W-1:0]         writes_issued,
  output logic [CNT_W-1:0]         rfo_issued
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + 2;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RFO   = 2'b11;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, is_cmd, dup, push, load, acked;
  logic [EW-1:0] head;

  assign full     = (count == (PW+1)'(DEPTH));
  assign in_ready = !full;
  assign is_cmd   = in_valid && (cmd_in != CMD_NOP);
  assign acked    = (state == ISSUE) && l2_ack;

`ifdef L2_DEDUP_EN
  logic [PW-1:0] last_ptr;
  assign last_ptr = wr_ptr - 1'b1;
  // The newest entry is still queued exactly when the FIFO is non-empty.
  assign dup = (count != '0) && (cmd_in != CMD_WRITE) &&
               (mem[last_ptr] == {cmd_in, addr_in});
`else
  assign dup = 1'b0;
`endif

  assign push = is_cmd && !full && !dup;

  // An ack on an empty FIFO with a same-cycle push forwards the incoming request.
  assign head = (count == '0) ? {cmd_in, addr_in} : mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (l2_ack) begin
          if ((count != '0) || push) load = 1'b1;
          else                       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {cmd_in, addr_in};
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      l2_valid      <= 1'b0;
      l2_cmd        <= CMD_NOP;
      l2_addr       <= '0;
      overflow      <= 1'b0;
      reads_issued  <= '0;
      writes_issued <= '0;
      rfo_issued    <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (is_cmd && full && !dup) overflow <= 1'b1;
      if (load) begin
        {l2_cmd, l2_addr} <= head;
        l2_valid          <= 1'b1;
      end else if (acked) begin
        l2_valid <= 1'b0;
      end
      if (acked) begin
        case (l2_cmd)
          CMD_READ:  reads_issued  <= reads_issued + 1'b1;
          CMD_WRITE: writes_issued <= writes_issued + 1'b1;
          CMD_RFO:   rfo_issued    <= rfo_issued + 1'b1;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l2_request_queue.sv
// Directed testbench for l2_request_queue; expected values are hand-derived per scenario.
module tb_l2_request_queue;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic [1:0]  cmd_in = 2'b00;
  logic [25:0] addr_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  l2_cmd;
  logic [25:0] l2_addr;
  logic        l2_valid;
  logic        l2_ack = 1'b0;
  logic [3:0]  count;
  logic        overflow;
  logic [31:0] reads_issued, writes_issued, rfo_issued;

  int checks = 0;
  int errors = 0;

  l2_request_queue dut (
    .Clock(Clock), .clear(clear), .cmd_in(cmd_in), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .l2_cmd(l2_cmd), .l2_addr(l2_addr),
    .l2_valid(l2_valid), .l2_ack(l2_ack), .count(count), .overflow(overflow),
    .reads_issued(reads_issued), .writes_issued(writes_issued), .rfo_issued(rfo_issued)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b0; l2_ack = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; in_valid = 1'b1; cmd_in = 2'b01; addr_in = 26'h1;
    step(); step();
    checks++;
    if (count !== 4'd0 || l2_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state count=%0d valid=%b ovf=%b rdy=%b required 0/0/0/1",
               count, l2_valid, overflow, in_ready);
    end
    checks++;
    if (reads_issued !== 0 || writes_issued !== 0 || rfo_issued !== 0 ||
        l2_cmd !== 2'b00 || l2_addr !== 26'h0) begin
      errors++;
      $display("FAIL reset_counters r=%0d w=%0d f=%0d cmd=%b addr=%h required all 0",
               reads_issued, writes_issued, rfo_issued, l2_cmd, l2_addr);
    end
    clear = 1'b0; in_valid = 1'b0; cmd_in = 2'b00;
  endtask

  task automatic test_single();
    do_clear();
    in_valid = 1'b1; cmd_in = 2'b01; addr_in = 26'h0000123;
    step();
    in_valid = 1'b0;
    checks++;
    if (l2_valid !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_after_push valid=%b count=%0d required 0/1", l2_valid, count);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (l2_valid !== 1'b1 || l2_cmd !== 2'b01 || l2_addr !== 26'h0000123 || count !== 4'd0) begin
        errors++;
        $display("FAIL single_hold%0d valid=%b cmd=%b addr=%h count=%0d required 1/01/0000123/0",
                 i, l2_valid, l2_cmd, l2_addr, count);
      end
      if (i < 3) step();
    end
    l2_ack = 1'b1;
    step();
    l2_ack = 1'b0;
    checks++;
    if (reads_issued !== 32'd1 || l2_valid !== 1'b0 || writes_issued !== 0 || rfo_issued !== 0) begin
      errors++;
      $display("FAIL single_ack reads=%0d valid=%b w=%0d f=%0d required 1/0/0/0",
               reads_issued, l2_valid, writes_issued, rfo_issued);
    end
    step();
    checks++;
    if (reads_issued !== 32'd1 || l2_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_stable reads=%0d valid=%b required 1/0", reads_issued, l2_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ecmd [3];
    logic [25:0] eaddr [3];
    ecmd[0] = 2'b10; eaddr[0] = 26'h10;
    ecmd[1] = 2'b11; eaddr[1] = 26'h20;
    ecmd[2] = 2'b01; eaddr[2] = 26'h30;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; cmd_in = ecmd[i]; addr_in = eaddr[i];
      step();
    end
    in_valid = 1'b0;
    l2_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (l2_valid !== 1'b1 || l2_cmd !== ecmd[i] || l2_addr !== eaddr[i]) begin
        errors++;
        $display("FAIL b2b_slot%0d valid=%b cmd=%b addr=%h required 1/%b/%h",
                 i, l2_valid, l2_cmd, l2_addr, ecmd[i], eaddr[i]);
      end
      step();
    end
    l2_ack = 1'b0;
    checks++;
    if (l2_valid !== 1'b0 || reads_issued !== 1 || writes_issued !== 1 || rfo_issued !== 1) begin
      errors++;
      $display("FAIL b2b_counters valid=%b r=%0d w=%0d f=%0d required 0/1/1/1",
               l2_valid, reads_issued, writes_issued, rfo_issued);
    end
  endtask

  task automatic test_full_overflow();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; cmd_in = 2'b01; addr_in = 26'(i);
      step();
      if (i == 8) begin
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL full_reached count=%0d rdy=%b ovf=%b required 8/0/0", count, in_ready, overflow);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_drop count=%0d ovf=%b required 8/1", count, overflow);
    end
    l2_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (l2_valid !== 1'b1 || l2_addr !== 26'(i)) begin
        errors++;
        $display("FAIL full_drain%0d valid=%b addr=%h required 1/%h", i, l2_valid, l2_addr, 26'(i));
      end
      step();
    end
    step();
    l2_ack = 1'b0;
    checks++;
    if (reads_issued !== 32'd9 || l2_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_issued reads=%0d valid=%b count=%0d ovf=%b required 9/0/0/1",
               reads_issued, l2_valid, count, overflow);
    end
  endtask

  task automatic test_nop_wrap();
    logic [1:0] c;
    do_clear();
    in_valid = 1'b1; cmd_in = 2'b00; addr_in = 26'h3ff;
    step(); step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || l2_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop_ignored count=%0d ovf=%b valid=%b required 0/0/0", count, overflow, l2_valid);
    end
    for (int i = 0; i < 20; i++) begin
      c = 2'(i % 3 + 1);
      in_valid = 1'b1; cmd_in = c; addr_in = 26'h100 + 26'(i);
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (l2_valid !== 1'b1 || l2_cmd !== c || l2_addr !== 26'h100 + 26'(i)) begin
        errors++;
        $display("FAIL wrap_entry%0d valid=%b cmd=%b addr=%h required 1/%b/%h",
                 i, l2_valid, l2_cmd, l2_addr, c, 26'h100 + 26'(i));
      end
      l2_ack = 1'b1;
      step();
      l2_ack = 1'b0;
    end
    checks++;
    if (reads_issued !== 7 || writes_issued !== 7 || rfo_issued !== 6 || l2_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_counters r=%0d w=%0d f=%0d valid=%b required 7/7/6/0",
               reads_issued, writes_issued, rfo_issued, l2_valid);
    end
  endtask

  task automatic test_clear_mid_issue();
    do_clear();
    in_valid = 1'b1; cmd_in = 2'b01; addr_in = 26'h55;
    step();
    addr_in = 26'h66;
    step();
    in_valid = 1'b0;
    checks++;
    if (l2_valid !== 1'b1 || l2_addr !== 26'h55 || count !== 4'd1) begin
      errors++;
      $display("FAIL clr_setup valid=%b addr=%h count=%0d required 1/55/1", l2_valid, l2_addr, count);
    end
    l2_ack = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; l2_ack = 1'b0;
    checks++;
    if (l2_valid !== 1'b0 || count !== 4'd0 || reads_issued !== 0) begin
      errors++;
      $display("FAIL clr_mid valid=%b count=%0d reads=%0d required 0/0/0", l2_valid, count, reads_issued);
    end
    step(); step();
    checks++;
    if (l2_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL clr_entry_lost valid=%b count=%0d required 0/0", l2_valid, count);
    end
  endtask

  task automatic test_dedup();
    int exp_cnt;
    int exp_reads;
`ifdef L2_DEDUP_EN
    exp_cnt = 1; exp_reads = 1;
`else
    exp_cnt = 2; exp_reads = 2;
`endif
    do_clear();
    in_valid = 1'b1; cmd_in = 2'b10; addr_in = 26'h3f;
    step();
    cmd_in = 2'b01; addr_in = 26'h40;
    step();
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'(exp_cnt) || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dedup_count count=%0d ovf=%b rdy=%b required %0d/0/1", count, overflow, in_ready, exp_cnt);
    end
    l2_ack = 1'b1;
    for (int i = 0; i < 5; i++) step();
    l2_ack = 1'b0;
    checks++;
    if (reads_issued !== 32'(exp_reads) || writes_issued !== 1 || count !== 4'd0 || l2_valid !== 1'b0) begin
      errors++;
      $display("FAIL dedup_issued r=%0d w=%0d count=%0d valid=%b required %0d/1/0/0",
               reads_issued, writes_issued, count, l2_valid, exp_reads);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_nop_wrap();
    test_clear_mid_issue();
    test_dedup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
